if_stage: RTL and testbench

- Instruction-fetch stage of the RV64 5-stage pipeline; sits directly upstream of the decode stage.
- Holds the fetch PC and issues in-order requests to a variable-latency instruction memory.
- Buffers returned words with their PCs in a small ring and presents one instruction per cycle (inst, pc_out) to decode.
- Handles hazard stall and branch/jump redirect; inserts the canonical NOP (addi x0,x0,0 = 32'h00000013) when it has nothing valid.

---
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Bundle of fetch-stage signals: instruction-memory request/response plus decode-facing controls.
// Latency: none, wires only.
// Backpressure: imem_ready stalls requests; stall holds the decode-facing outputs.
interface if_stage_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc_out;
    logic            inst_valid;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr, inst, pc_out, inst_valid,
        input  imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );

    // Memory / decode / hazard-unit side
    modport slave (
        input  imem_req, imem_addr, inst, pc_out, inst_valid,
        output imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: in-order requests to variable-latency imem, ring buffer of returned words, one inst/cycle to decode.
// Latency: request handshake at edge t, response at edge t+1, instruction visible after edge t+2 (no bypass).
// Backpressure: requests gated by ring credit (allocated + to-be-dropped < DEPTH); stall holds output and stops pops.
module if_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic      clk,
    input  logic      rst,
    if_stage_if.master bus
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam int          SW  = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0]  fpc;
    logic [XLEN-1:0]  ent_pc   [DEPTH];
    logic [31:0]      ent_word [DEPTH];
    logic [DEPTH-1:0] ent_filled;
    logic [PW-1:0]    alloc_ptr, fill_ptr, head_ptr;
    logic [CW-1:0]    count;      // allocated entries
    logic [CW-1:0]    pend;       // allocated but not yet filled
    logic [CW-1:0]    drop_cnt;   // in-flight responses belonging to a squashed path

    logic [31:0]      inst_q;
    logic [XLEN-1:0]  pc_q;
    logic             vld_q;

    logic [SW-1:0]    used;
    logic             req, push, drop_rsp, fill_rsp, pop;
    logic [CW-1:0]    outst, drop_redir;

    // Credit, handshake and response classification
    always_comb begin
        used       = {1'b0, count} + {1'b0, drop_cnt};
        req        = rst && !bus.redirect && (used < SW'(DEPTH));
        push       = req && bus.imem_ready;
        drop_rsp   = bus.imem_rvalid && (drop_cnt != '0);
        fill_rsp   = bus.imem_rvalid && (drop_cnt == '0) && (pend != '0);
        pop        = !bus.stall && ent_filled[head_ptr];
        // On redirect every outstanding response becomes garbage; one arriving now is already consumed
        outst      = drop_cnt + pend;
        drop_redir = outst - CW'(bus.imem_rvalid && (outst != '0));
    end

    // Ring payload storage, no reset needed: guarded by filled bits
    always_ff @(posedge clk) begin
        if (push)
            ent_pc[alloc_ptr] <= fpc;
        if (fill_rsp && !bus.redirect)
            ent_word[fill_ptr] <= bus.imem_rdata;
    end

    // Fetch PC, ring bookkeeping and decode-facing output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc        <= RESET_PC & ~XLEN'(3);
            ent_filled <= '0;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            count      <= '0;
            pend       <= '0;
            drop_cnt   <= '0;
            inst_q     <= NOP;
            pc_q       <= '0;
            vld_q      <= 1'b0;
        end else if (bus.redirect) begin
            fpc        <= bus.redirect_pc & ~XLEN'(3);
            ent_filled <= '0;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            count      <= '0;
            pend       <= '0;
            drop_cnt   <= drop_redir;
            inst_q     <= NOP;
            pc_q       <= '0;
            vld_q      <= 1'b0;
        end else begin
            if (push) begin
                fpc                   <= fpc + XLEN'(4);
                alloc_ptr             <= alloc_ptr + PW'(1);
                ent_filled[alloc_ptr] <= 1'b0;
            end
            if (drop_rsp)
                drop_cnt <= drop_cnt - CW'(1);
            if (fill_rsp) begin
                fill_ptr             <= fill_ptr + PW'(1);
                ent_filled[fill_ptr] <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
            pend  <= pend + CW'(push) - CW'(fill_rsp);
            if (!bus.stall) begin
                if (pop) begin
                    inst_q               <= ent_word[head_ptr];
                    pc_q                 <= ent_pc[head_ptr];
                    vld_q                <= 1'b1;
                    head_ptr             <= head_ptr + PW'(1);
                    ent_filled[head_ptr] <= 1'b0;
                end else begin
                    inst_q <= NOP;
                    pc_q   <= '0;
                    vld_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fpc;
    assign bus.inst       = inst_q;
    assign bus.pc_out     = pc_q;
    assign bus.inst_valid = vld_q;
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    localparam int          XLEN     = 64;
    localparam int          DEPTH    = 2;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_stage_if #(.XLEN(XLEN)) bus ();

    if_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: program-order queue of live fetches, plus a count of squashed in-flight responses
    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
        bit          filled;
    } ent_t;

    ent_t        ring[$];
    int          drop;
    logic [63:0] m_fpc;
    logic [31:0] m_inst;
    logic [63:0] m_pc;
    bit          m_vld;

    // Memory side: addresses accepted and not yet answered, in order
    logic [63:0] memq[$];

    int p_stall, p_redir, p_ready, p_rvalid;
    bit flush = 0;

    function automatic logic [31:0] memword(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        ring.delete();
        drop   = 0;
        m_fpc  = RESET_PC;
        m_inst = NOP;
        m_pc   = 64'h0;
        m_vld  = 0;
    endtask

    task automatic model_step(input bit accepted);
        int   unf;
        int   out;
        bit   head_rdy;
        ent_t e;
        if (bus.redirect) begin
            unf = 0;
            foreach (ring[i]) if (!ring[i].filled) unf++;
            out  = drop + unf;
            drop = out - ((bus.imem_rvalid && out > 0) ? 1 : 0);
            ring.delete();
            m_fpc  = bus.redirect_pc & ~64'h3;
            m_inst = NOP;
            m_pc   = 64'h0;
            m_vld  = 0;
            return;
        end
        head_rdy = (ring.size() > 0) && ring[0].filled;
        if (bus.imem_rvalid) begin
            if (drop > 0) begin
                drop--;
            end else begin
                for (int i = 0; i < ring.size(); i++) begin
                    if (!ring[i].filled) begin
                        e        = ring[i];
                        e.word   = bus.imem_rdata;
                        e.filled = 1;
                        ring[i]  = e;
                        break;
                    end
                end
            end
        end
        if (!bus.stall) begin
            if (head_rdy) begin
                m_inst = ring[0].word;
                m_pc   = ring[0].pc;
                m_vld  = 1;
                void'(ring.pop_front());
            end else begin
                m_inst = NOP;
                m_pc   = 64'h0;
                m_vld  = 0;
            end
        end
        if (accepted) begin
            e.pc     = m_fpc;
            e.word   = 32'h0;
            e.filled = 0;
            ring.push_back(e);
            m_fpc = m_fpc + 64'd4;
        end
    endtask

    // One clock: drive at negedge, check request side before posedge, check outputs at next negedge
    task automatic cycle();
        logic        exp_req, acc, m_acc;
        logic [63:0] acc_addr;
        if (flush) begin
            bus.stall    = 1'b0;
            bus.redirect = 1'b0;
            bus.imem_ready = 1'b0;
        end else begin
            bus.stall      = ($urandom_range(99) < p_stall);
            bus.redirect   = ($urandom_range(99) < p_redir);
            bus.imem_ready = ($urandom_range(99) < p_ready);
        end
        if ($urandom_range(3) == 0)
            bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        else
            bus.redirect_pc = {32'h0, $urandom};
        if (memq.size() > 0 && (flush || $urandom_range(99) < p_rvalid)) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memword(memq[0]);
        end else if (memq.size() == 0 && !flush && $urandom_range(99) < 3) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = $urandom;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        exp_req = rst && !bus.redirect && (ring.size() + drop < DEPTH);
        chk("imem_req", bus.imem_req, exp_req);
        chk("imem_addr", bus.imem_addr, m_fpc);
        acc      = bus.imem_req && bus.imem_ready;
        acc_addr = bus.imem_addr;
        m_acc    = exp_req && bus.imem_ready;
        @(posedge clk);
        model_step(m_acc);
        if (bus.imem_rvalid && memq.size() > 0) void'(memq.pop_front());
        if (acc) memq.push_back(acc_addr);
        @(negedge clk);
        chk("inst", bus.inst, m_inst);
        chk("pc_out", bus.pc_out, m_pc);
        chk("inst_valid", bus.inst_valid, m_vld);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_inst"}, bus.inst, NOP);
        chk({tag, "_pc_out"}, bus.pc_out, 64'h0);
        chk({tag, "_inst_valid"}, bus.inst_valid, 1'b0);
        chk({tag, "_imem_req"}, bus.imem_req, 1'b0);
        chk({tag, "_imem_addr"}, bus.imem_addr, RESET_PC);
    endtask

    task automatic run(input int n, input int ps, input int pr, input int prdy, input int prv);
        p_stall  = ps;
        p_redir  = pr;
        p_ready  = prdy;
        p_rvalid = prv;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        model_reset();

        // Reset state, held across a clock edge
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Ideal memory: ready always, response one cycle after request
        run(20, 0, 0, 100, 100);
        // Heavy stall
        run(40, 60, 0, 100, 100);
        // Slow memory acceptance and response
        run(40, 0, 0, 20, 50);
        // Long ready-low stretch
        run(6, 10, 0, 0, 60);
        // Redirects mixed with everything
        run(300, 25, 10, 70, 60);

        // Reset with a response outstanding; it returns after release
        run(2, 0, 0, 100, 0);
        #2;
        rst             = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.redirect    = 1'b0;
        bus.stall       = 1'b0;
        bus.imem_ready  = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        @(negedge clk);
        rst   = 1'b1;
        flush = 1;
        for (int i = 0; i < 8 && memq.size() > 0; i++) cycle();
        flush = 0;
        run(20, 0, 0, 100, 100);
        run(300, 20, 8, 60, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
